tg_write_arbiter: RTL and testbench

- Shares the single text-grid RAM write port (`tg_we`/`tg_addr`/`tg_input`) among NUM_REQ requesters. Typical requesters: keyboard terminal controller, status-line writer, compiler/result printer.
- Each requester uses a valid/ready handshake; a round-robin arbiter picks one write per cycle.
- A built-in clear engine blanks the whole screen on request.
- Sits between the requesters and the text-grid BRAM/renderer, all in the pixel clock domain.

---
 rtl/tg_write_arbiter_pkg.sv | 26 ++
 rtl/tg_write_arbiter_rr_arbiter.sv | 34 +++
 rtl/tg_write_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_tg_write_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tg_write_arbiter_pkg.sv
// Shared constants, types and helpers for the text-grid write arbiter.
// Consumed by tg_write_arbiter (optional feature macro: TG_BURST_LOCK_EN).
package tg_pkg;

    localparam int SCREEN_WIDTH  = 76;
    localparam int SCREEN_HEIGHT = 44;
    localparam int CELLS         = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int ADDR_W        = $clog2(CELLS);

    localparam logic [7:0] ASCII_SPACE   = 8'd32;
    localparam logic [7:0] ASCII_NEWLINE = 8'd10;

    typedef logic [ADDR_W-1:0] tg_addr_t;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK  = 2'd1,
        CLEAR = 2'd2
    } tg_arb_state_e;

    // Requester index reached after stepping 'offset' places from 'base' on a ring of n.
    function automatic int rr_wrap(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/tg_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
// The pointer register is owned by the instantiating module.
module rr_arbiter
    import tg_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr_wrap(int'(ptr_i), k, NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/tg_write_arbiter.sv
// Shares the text-grid RAM write port among NUM_REQ valid/ready requesters and owns a
// full-screen clear engine. Define TG_BURST_LOCK_EN to hold the grant for multi-beat bursts.
module tg_write_arbiter
    import tg_pkg::tg_arb_state_e, tg_pkg::ARB, tg_pkg::LOCK, tg_pkg::CLEAR;
#(
    parameter int SCREEN_WIDTH  = tg_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = tg_pkg::SCREEN_HEIGHT,
    parameter int NUM_REQ       = 3,
    parameter int CLEAR_CHAR    = 32,
    localparam int CELLS        = SCREEN_WIDTH * SCREEN_HEIGHT,
    localparam int ADDR_W       = $clog2(CELLS),
    localparam int GID_W        = $clog2(NUM_REQ)
) (
    input  logic                           pixel_clk_in,
    input  logic                           rst_n_in,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    output logic [NUM_REQ-1:0]             req_ready_out,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_in,
    input  logic [NUM_REQ-1:0][7:0]        req_char_in,
    input  logic [NUM_REQ-1:0]             req_last_in,
    input  logic                           clear_in,
    output logic                           clear_busy_out,
    output logic [GID_W-1:0]               grant_id_out,
    output logic                           oob_drop_out,
    output logic                           tg_we,
    output logic [ADDR_W-1:0]              tg_addr,
    output logic [7:0]                     tg_input
);

    tg_arb_state_e     state_q, state_d;
    logic [GID_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              tg_we_q, tg_we_d;
    logic [ADDR_W-1:0] tg_addr_q, tg_addr_d;
    logic [7:0]        tg_data_q, tg_data_d;
    logic [GID_W-1:0]  gid_q, gid_d;
    logic              oob_q, oob_d;
    logic              busy_q, busy_d;

`ifdef TG_BURST_LOCK_EN
    logic [GID_W-1:0]  lock_id_q, lock_id_d;
`else
    logic              unused_last;
    assign unused_last = ^req_last_in;
`endif

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_grant;
    logic [GID_W-1:0]   arb_idx;
    logic               arb_any;
    logic [ADDR_W-1:0]  sel_addr;
    logic [7:0]         sel_char;
    logic               sel_last;
    logic               in_range;

    // Clear start outranks requesters; a locked burst defers the clear instead.
    always_comb begin
        arb_req = req_valid_in;
`ifdef TG_BURST_LOCK_EN
        if (state_q == LOCK) begin
            arb_req = req_valid_in & (NUM_REQ'(1) << lock_id_q);
        end
`endif
        if (!rst_n_in || state_q == CLEAR || (state_q == ARB && clear_in)) begin
            arb_req = '0;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GID_W)
    ) u_rr_arbiter (
        .req_i   (arb_req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign req_ready_out = arb_grant;

    // One-hot AND-OR mux of the granted requester's beat.
    always_comb begin
        sel_addr = '0;
        sel_char = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr = sel_addr | req_addr_in[i];
                sel_char = sel_char | req_char_in[i];
                sel_last = sel_last | req_last_in[i];
            end
        end
        in_range = (int'(sel_addr) < CELLS);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        clr_cnt_d = clr_cnt_q;
        tg_we_d   = 1'b0;
        tg_addr_d = tg_addr_q;
        tg_data_d = tg_data_q;
        gid_d     = gid_q;
        oob_d     = 1'b0;
        busy_d    = 1'b0;
`ifdef TG_BURST_LOCK_EN
        lock_id_d = lock_id_q;
`endif
        unique case (state_q)
            CLEAR: begin
                tg_we_d   = 1'b1;
                tg_addr_d = clr_cnt_q;
                tg_data_d = 8'(CLEAR_CHAR);
                busy_d    = 1'b1;
                if (clr_cnt_q == ADDR_W'(CELLS - 1)) begin
                    state_d   = ARB;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                if (state_q == ARB && clear_in) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end else if (arb_any) begin
                    // Out-of-range beats complete the handshake but never reach the RAM.
                    tg_we_d   = in_range;
                    oob_d     = !in_range;
                    tg_addr_d = sel_addr;
                    tg_data_d = sel_char;
                    gid_d     = arb_idx;
                    ptr_d     = (arb_idx == GID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
`ifdef TG_BURST_LOCK_EN
                    if (sel_last) begin
                        state_d = ARB;
                    end else begin
                        state_d   = LOCK;
                        lock_id_d = arb_idx;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            clr_cnt_q <= '0;
            tg_we_q   <= 1'b0;
            tg_addr_q <= '0;
            tg_data_q <= '0;
            gid_q     <= '0;
            oob_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef TG_BURST_LOCK_EN
            lock_id_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge next-state values.
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            clr_cnt_q <= clr_cnt_d;
            tg_we_q   <= tg_we_d;
            tg_addr_q <= tg_addr_d;
            tg_data_q <= tg_data_d;
            gid_q     <= gid_d;
            oob_q     <= oob_d;
            busy_q    <= busy_d;
`ifdef TG_BURST_LOCK_EN
            lock_id_q <= lock_id_d;
`endif
        end
    end

    assign tg_we          = tg_we_q;
    assign tg_addr        = tg_addr_q;
    assign tg_input       = tg_data_q;
    assign grant_id_out   = gid_q;
    assign oob_drop_out   = oob_q;
    assign clear_busy_out = busy_q;

    a_ready_onehot: assert property (@(posedge pixel_clk_in) disable iff (!rst_n_in)
        $onehot0(req_ready_out));
    a_no_ready_in_clear: assert property (@(posedge pixel_clk_in) disable iff (!rst_n_in)
        (state_q == CLEAR) |-> (req_ready_out == '0));

endmodule

// File: tb/tb_tg_write_arbiter.sv
// Directed bench for tg_write_arbiter: vector table for arbitration/OOB plus hand-written
// sequences for clear, reset-during-clear and burst behaviour (TG_BURST_LOCK_EN aware).
module tb_tg_write_arbiter;

    localparam int NR    = 3;
    localparam int AW    = 12;
    localparam int CELLS = 3344;
    localparam int NVEC  = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     valid;
    logic [NR-1:0]     ready;
    logic [NR-1:0][AW-1:0] addr;
    logic [NR-1:0][7:0]    ch;
    logic [NR-1:0]     last;
    logic              clear;
    logic              busy;
    logic [1:0]        gid;
    logic              oob;
    logic              we;
    logic [AW-1:0]     tg_addr;
    logic [7:0]        tg_input;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tg_write_arbiter dut (
        .pixel_clk_in   (clk),
        .rst_n_in       (rst_n),
        .req_valid_in   (valid),
        .req_ready_out  (ready),
        .req_addr_in    (addr),
        .req_char_in    (ch),
        .req_last_in    (last),
        .clear_in       (clear),
        .clear_busy_out (busy),
        .grant_id_out   (gid),
        .oob_drop_out   (oob),
        .tg_we          (we),
        .tg_addr        (tg_addr),
        .tg_input       (tg_input)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [NR-1:0]         valid;
        logic [NR-1:0][AW-1:0] addr;
        logic [NR-1:0][7:0]    ch;
        logic [NR-1:0]         exp_ready;
        logic                  exp_we;
        logic [AW-1:0]         exp_addr;
        logic [7:0]            exp_ch;
        logic [1:0]            exp_gid;
        logic                  exp_oob;
    } vec_t;

    vec_t vecs[NVEC];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        logic [1:0]    exp_g;
        logic [AW-1:0] exp_a;

        // Rows 0-5: all valid from reset, pointer walks 0,1,2,0,1,2.
        for (int k = 0; k < 6; k++) begin
            vecs[k] = '{3'b111, {12'd30, 12'd20, 12'd10}, {8'd67, 8'd66, 8'd65},
                        3'(1 << (k % 3)), 1'b1, 12'(10 * (k % 3 + 1)), 8'(65 + k % 3),
                        2'(k % 3), 1'b0};
        end
        vecs[6]  = '{3'b000, '0, '0, 3'b000, 1'b0, 12'd0, 8'd0, 2'd0, 1'b0};
        vecs[7]  = '{3'b001, {12'd0, 12'd0, 12'd77}, {8'd0, 8'd0, 8'd97},
                     3'b001, 1'b1, 12'd77, 8'd97, 2'd0, 1'b0};
        vecs[8]  = '{3'b100, {12'd3344, 12'd0, 12'd0}, {8'd88, 8'd0, 8'd0},
                     3'b100, 1'b0, 12'd0, 8'd0, 2'd0, 1'b1};
        vecs[9]  = '{3'b100, {12'd3343, 12'd0, 12'd0}, {8'd89, 8'd0, 8'd0},
                     3'b100, 1'b1, 12'd3343, 8'd89, 2'd2, 1'b0};
        vecs[10] = '{3'b101, {12'd6, 12'd0, 12'd5}, {8'd50, 8'd0, 8'd49},
                     3'b001, 1'b1, 12'd5, 8'd49, 2'd0, 1'b0};
        vecs[11] = '{3'b101, {12'd6, 12'd0, 12'd5}, {8'd50, 8'd0, 8'd49},
                     3'b100, 1'b1, 12'd6, 8'd50, 2'd2, 1'b0};
        vecs[12] = '{3'b110, {12'd8, 12'd7, 12'd0}, {8'd52, 8'd51, 8'd0},
                     3'b010, 1'b1, 12'd7, 8'd51, 2'd1, 1'b0};
        vecs[13] = '{3'b010, {12'd0, 12'd7, 12'd0}, {8'd0, 8'd51, 8'd0},
                     3'b010, 1'b1, 12'd7, 8'd51, 2'd1, 1'b0};
        vecs[14] = '{3'b011, {12'd0, 12'd7, 12'd1}, {8'd0, 8'd51, 8'd40},
                     3'b001, 1'b1, 12'd1, 8'd40, 2'd0, 1'b0};

        // Reset state, with requesters valid to show ready is held low.
        rst_n = 1'b0;
        valid = 3'b111;
        addr  = '0;
        ch    = '0;
        last  = '1;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {ready, we, tg_addr, tg_input, busy, oob, gid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        valid = '0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            valid = vecs[i].valid;
            addr  = vecs[i].addr;
            ch    = vecs[i].ch;
            #2;
            check($sformatf("vec%0d_ready", i), ready, vecs[i].exp_ready);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_we_oob", i), {we, oob}, {vecs[i].exp_we, vecs[i].exp_oob});
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d_write", i), {tg_addr, tg_input, gid},
                      {vecs[i].exp_addr, vecs[i].exp_ch, vecs[i].exp_gid});
            end
        end

        // Clear pulse while requester 1 waits: full blanking, then requester 1 is served.
        @(negedge clk);
        valid   = 3'b010;
        addr    = '0;
        ch      = '0;
        addr[1] = 12'd100;
        ch[1]   = 8'd70;
        clear   = 1'b1;
        #2;
        check("clear_priority_ready", ready, 3'b000);
        @(posedge clk);
        #1;
        check("clear_entry", {ready, busy, we}, 5'd0);
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            @(posedge clk);
            #1;
            check("clear_write", {ready, busy, we, tg_addr, tg_input, gid},
                  {((i == CELLS - 1) ? 3'b010 : 3'b000), 1'b1, 1'b1, 12'(i), 8'd32, 2'd0});
        end
        @(posedge clk);
        #1;
        check("after_clear_grant", {we, busy, tg_addr, tg_input, gid},
              {1'b1, 1'b0, 12'd100, 8'd70, 2'd1});
        @(negedge clk);
        valid = '0;

        // Reset in the middle of a clear abandons it.
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        repeat (1001) @(posedge clk);
        #1;
        check("mid_clear_addr", {busy, we, tg_addr}, {1'b1, 1'b1, 12'd1000});
        #2;
        rst_n = 1'b0;
        valid = 3'b111;
        #1;
        check("async_reset_outputs", {ready, we, tg_addr, tg_input, busy, oob, gid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        valid = '0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("no_clear_after_reset", {busy, we}, 2'b00);
        end
        @(negedge clk);
        valid = 3'b111;
        addr  = {12'd33, 12'd22, 12'd11};
        ch    = {8'd75, 8'd74, 8'd73};
        #2;
        check("post_reset_pointer", ready, 3'b001);
        @(posedge clk);
        #1;
        check("post_reset_write", {we, tg_addr, tg_input, gid}, {1'b1, 12'd11, 8'd73, 2'd0});
        @(negedge clk);
        valid = '0;

        // Burst of 8 from requester 0 while requester 1 is continuously valid.
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        b = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            valid   = {1'b0, 1'b1, (b < 8)};
            addr[0] = 12'(200 + b);
            ch[0]   = 8'(48 + b);
            last[0] = (b == 7);
            addr[1] = 12'd300;
            ch[1]   = 8'd90;
            last[1] = 1'b1;
`ifdef TG_BURST_LOCK_EN
            exp_g = (k < 8) ? 2'd0 : 2'd1;
`else
            exp_g = 2'(k % 2);
`endif
            exp_a = (exp_g == 2'd0) ? 12'(200 + b) : 12'd300;
            @(posedge clk);
            #1;
            check($sformatf("burst_beat%0d", k), {we, gid, tg_addr}, {1'b1, exp_g, exp_a});
            if (exp_g == 2'd0) b++;
        end
        @(negedge clk);
        valid = '0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
